// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port between the processor
// memory stage (absolute priority, never stalled) and one auxiliary burst
// reader that only uses the cycles in which the processor leaves the port idle.
// Returned auxiliary words are tagged through a RD_LATENCY-deep valid pipe, so
// processor reads interleaved with a burst are never flagged as auxiliary data.
module dmem_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int LEN_W      = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_data,
    input  logic              cpu_wren,
    input  logic              cpu_active,
    output logic [31:0]       cpu_q,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_base,
    input  logic [LEN_W-1:0]  aux_len,
    output logic              aux_busy,
    output logic [31:0]       aux_rdata,
    output logic              aux_rvalid,
    output logic              aux_done,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    input  logic [31:0]       mem_q
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]          state;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   aux_addr;
    logic [LEN_W-1:0]    idx;
    logic [LEN_W-1:0]    rem;
    // vld_pipe[i] is 1 when the word issued i cycles ago was an auxiliary read
    logic [RD_LATENCY:1] vld_pipe;
    logic                issue;

    // An auxiliary read goes out only while bursting, words remain and the
    // processor does not own the port this cycle.
    assign issue    = (state == S_BURST) && !cpu_active && (rem != '0);
    assign aux_addr = base_q + ADDR_W'(idx);
    assign cpu_q    = mem_q;

    // Port mux: processor traffic passes through except on auxiliary issue cycles
    always_comb begin
        mem_addr = cpu_addr;
        mem_data = cpu_data;
        mem_wren = cpu_wren & cpu_active;
        if (issue) begin
            mem_addr = {{(32-ADDR_W){1'b0}}, aux_addr};
            mem_wren = 1'b0;
        end
    end

    // Burst sequencer: accept request, count issues, wait for the tag pipe to empty
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            base_q   <= '0;
            idx      <= '0;
            rem      <= '0;
            aux_busy <= 1'b0;
            aux_done <= 1'b0;
        end else begin
            aux_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (aux_req) begin
                        if (aux_len != '0) begin
                            base_q   <= aux_base;
                            rem      <= aux_len;
                            idx      <= '0;
                            aux_busy <= 1'b1;
                            state    <= S_BURST;
                        end else begin
                            // empty burst: no access, just acknowledge
                            aux_done <= 1'b1;
                        end
                    end
                end
                S_BURST: begin
                    if (issue) begin
                        idx <= idx + LEN_W'(1);
                        rem <= rem - LEN_W'(1);
                        if (rem == LEN_W'(1)) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // last tagged word has left the pipe and is on aux_rvalid now
                    if (vld_pipe == '0) begin
                        aux_done <= 1'b1;
                        aux_busy <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tag shift register, aligned with the RAM read latency
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= issue;
            for (int i = 2; i <= RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Register returned data; only tagged words raise aux_rvalid
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aux_rvalid <= 1'b0;
            aux_rdata  <= '0;
        end else begin
            aux_rvalid <= vld_pipe[RD_LATENCY];
            aux_rdata  <= mem_q;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized bench for dmem_port_arbiter. A behavioural RAM sits on the mem_*
// port; expected auxiliary traffic is predicted from the burst rules: every
// idle processor cycle issues the next address (base+i mod 4096), each word
// returns LAT+1 cycles after its issue, and done follows the last word.
module tb_dmem_port_arbiter;
    localparam int LAT = 1;

    logic        clock, reset;
    logic [31:0] cpu_addr, cpu_data, cpu_q;
    logic        cpu_wren, cpu_active;
    logic        aux_req, aux_busy, aux_rvalid, aux_done;
    logic [11:0] aux_base;
    logic [7:0]  aux_len;
    logic [31:0] aux_rdata, mem_addr, mem_data, mem_q;
    logic        mem_wren;

    logic [31:0] ram  [0:4095];
    logic [31:0] gold [0:4095];
    int n_checks = 0;
    int n_err    = 0;

    dmem_port_arbiter #(.ADDR_W(12), .LEN_W(8), .RD_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wren(cpu_wren),
        .cpu_active(cpu_active), .cpu_q(cpu_q),
        .aux_req(aux_req), .aux_base(aux_base), .aux_len(aux_len),
        .aux_busy(aux_busy), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
        .aux_done(aux_done),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // synchronous RAM, one cycle read latency
    always @(posedge clock) begin
        if (mem_wren) ram[mem_addr[11:0]] <= mem_data;
        mem_q <= ram[mem_addr[11:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cpu_idle();
        cpu_active = 1'b0;
        cpu_addr   = 32'hDEAD_0000 | 32'($urandom_range(0, 4095));
        cpu_wren   = 1'($urandom_range(0, 1));
        cpu_data   = $urandom;
    endtask

    // mode 0: processor idle, 1: random processor traffic,
    // 2: single store 0xAB to 0x020 in the cycle after the first issue
    task automatic run_burst(input logic [11:0] base, input int len, input int mode);
        int          issue_t[$];
        int          nis = 0, rvp = 0, k = 0;
        bit          done_seen = 0, act, exp_iss, exp_rv, exp_done, exp_busy;
        logic [11:0] ea, wa;
        aux_req  = 1'b1;
        aux_base = base;
        aux_len  = 8'(len);
        cpu_idle();
        #1;
        chk("req_addr", mem_addr, cpu_addr);
        chk("req_rvalid", 32'(aux_rvalid), 32'd0);
        chk("req_busy", 32'(aux_busy), 32'd0);
        while (!done_seen && k < 1500) begin
            @(negedge clock);
            k++;
            exp_done = (len == 0) ? (k == 1) : (nis == len && k == issue_t[len-1] + LAT + 2);
            exp_busy = (len != 0) && !exp_done;
            // requests while busy must be ignored
            aux_req  = exp_busy ? 1'($urandom_range(0, 1)) : 1'b0;
            aux_base = 12'($urandom);
            aux_len  = 8'($urandom);
            act = (mode == 1) ? ($urandom_range(0, 9) < 3) : (mode == 2) ? (k == 2) : 1'b0;
            if (act) begin
                cpu_active = 1'b1;
                if (mode == 2) begin
                    wa = 12'h020;
                    cpu_wren = 1'b1;
                    gold[wa] = 32'h0000_00AB;
                end else begin
                    wa = 12'($urandom);
                    cpu_wren = 1'($urandom_range(0, 1));
                end
                cpu_addr = {20'd0, wa};
                cpu_data = gold[wa];
            end else begin
                cpu_idle();
            end
            exp_iss = !act && (nis < len);
            ea = base + 12'(nis);
            if (exp_iss) begin
                issue_t.push_back(k);
                nis++;
            end
            exp_rv = (rvp < issue_t.size()) && (issue_t[rvp] == k - LAT - 1);
            #1;
            chk("issue", 32'(mem_addr != cpu_addr), 32'(exp_iss));
            if (exp_iss) begin
                chk("aux_addr", mem_addr, {20'd0, ea});
                chk("aux_wren", 32'(mem_wren), 32'd0);
            end else begin
                chk("cpu_wren", 32'(mem_wren), 32'(cpu_wren & cpu_active));
            end
            chk("mem_data", mem_data, cpu_data);
            chk("rvalid", 32'(aux_rvalid), 32'(exp_rv));
            if (exp_rv) begin
                chk("rdata", aux_rdata, gold[base + 12'(rvp)]);
                rvp++;
            end
            chk("done", 32'(aux_done), 32'(exp_done));
            chk("busy", 32'(aux_busy), 32'(exp_busy));
            if (exp_done) done_seen = 1;
        end
        if (!done_seen) chk("timeout", 32'd0, 32'd1);
        chk("n_words", 32'(rvp), 32'(len));
    endtask

    initial begin
        int nrv;
        for (int i = 0; i < 4096; i++) begin
            ram[i]  = 32'(i * 3);
            gold[i] = 32'(i * 3);
        end
        reset      = 1'b0;
        aux_req    = 1'b0;
        aux_base   = '0;
        aux_len    = '0;
        cpu_active = 1'b0;
        cpu_addr   = 32'd5;
        cpu_wren   = 1'b1;
        cpu_data   = 32'h1234;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_addr", mem_addr, 32'd5);
        chk("rst_wren", 32'(mem_wren), 32'd0);
        chk("rst_busy", 32'(aux_busy), 32'd0);
        chk("rst_rvalid", 32'(aux_rvalid), 32'd0);
        chk("rst_done", 32'(aux_done), 32'd0);
        chk("rst_rdata", aux_rdata, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        run_burst(12'h010, 4, 0);
        run_burst(12'h010, 4, 2);
        chk("ram_020", ram[12'h020], 32'h0000_00AB);
        run_burst(12'hFFE, 3, 0);
        run_burst(12'h000, 0, 0);

        // reset after two of five words have returned
        aux_req  = 1'b1;
        aux_base = 12'h100;
        aux_len  = 8'd5;
        cpu_idle();
        @(negedge clock);
        aux_req = 1'b0;
        nrv = 0;
        for (int c = 0; c < 20 && nrv < 2; c++) begin
            @(negedge clock);
            #1;
            if (aux_rvalid) nrv++;
        end
        chk("pre_rst_words", 32'(nrv), 32'd2);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(aux_busy), 32'd0);
        chk("mid_rst_rvalid", 32'(aux_rvalid), 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (c == 2) reset = 1'b1;
            #1;
            chk("post_rst_done", 32'(aux_done), 32'd0);
            chk("post_rst_rvalid", 32'(aux_rvalid), 32'd0);
            chk("post_rst_busy", 32'(aux_busy), 32'd0);
        end
        run_burst(12'h100, 5, 0);

        for (int t = 0; t < 20; t++)
            run_burst(12'($urandom), $urandom_range(0, 12), $urandom_range(0, 1));
        run_burst(12'hF80, 255, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between the processor memory stage and one auxiliary burst reader, such as the Tetris board/VGA renderer.
- The processor always wins and is never stalled; the auxiliary reader uses only the cycles in which the processor's `isLWSW` is low.
- Sits in the wrapper between the processor dmem outputs and the dmem RAM.
- Sequences auxiliary read bursts and tags the returning read data.

Parameters:
- ADDR_W, 12, dmem word-address width; auxiliary addresses wrap modulo 2^ADDR_W.
- LEN_W, 8, burst-length width; maximum burst is 2^LEN_W-1 words.
- RD_LATENCY, 1, cycles from address presented at mem_addr to valid mem_q (1..4).

Ports:
- clock  in  1  master clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_addr  in  32  processor address_dmem.
- cpu_data  in  32  processor store data.
- cpu_wren  in  1  processor write enable.
- cpu_active  in  1  processor isLWSW; memory stage owns the port this cycle.
- cpu_q  out  32  read data to processor q_dmem; combinational copy of mem_q.
- aux_req  in  1  start a burst; sampled only while aux_busy=0.
- aux_base  in  ADDR_W  burst start address.
- aux_len  in  LEN_W  number of words to read.
- aux_busy  out  1  burst accepted and not yet complete.
- aux_rdata  out  32  returned burst word.
- aux_rvalid  out  1  aux_rdata valid this cycle; words return in address order.
- aux_done  out  1  one-cycle pulse after the last word is returned.
- mem_addr  out  32  to dmem address.
- mem_data  out  32  to dmem write data.
- mem_wren  out  1  to dmem write enable.
- mem_q  in  32  from dmem read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - aux_busy, aux_rvalid and aux_done are 0.
  - aux_rdata is 0.
  - Issue index, remaining count and tag pipe are cleared.
  - mem_addr, mem_data and mem_wren follow the cpu_* inputs combinationally at all times except AUX issue cycles, so processor traffic continues during reset.
- Port mux (combinational):
  - If cpu_active=1 or no auxiliary issue this cycle: mem_addr=cpu_addr, mem_data=cpu_data, mem_wren=cpu_wren&cpu_active.
  - On an auxiliary issue cycle: mem_addr={zero-extend, aux_base+idx mod 2^ADDR_W}, mem_wren=0, mem_data=cpu_data.
- State machine IDLE / BURST / DRAIN:
  - IDLE, aux_req=1 and aux_len!=0: latch aux_base and aux_len, idx<=0, aux_busy<=1, go to BURST.
  - IDLE, aux_req=1 and aux_len=0: no memory access; aux_done pulses the next cycle; aux_busy stays 0; stay in IDLE.
  - BURST: an issue cycle is any cycle with cpu_active=0 and idx<len.
    - Each issue cycle increments idx and pushes a 1 into the RD_LATENCY-deep tag shift register.
    - A non-issue cycle pushes a 0.
    - When idx reaches len, go to DRAIN.
  - DRAIN: keep shifting the tag register with 0s.
  - aux_rvalid and aux_rdata: aux_rvalid is registered from the tag-register output (1 when that output is 1); aux_rdata is registered from mem_q in the same cycle.
  - Leaving DRAIN: when the tag register is all zero and the last valid word has been emitted, pulse aux_done for 1 cycle, clear aux_busy, return to IDLE.
- Timing:
  - With cpu_active=0 throughout, an N-word burst gives N consecutive aux_rvalid cycles.
  - The first aux_rvalid is RD_LATENCY+1 cycles after the first issue.
  - aux_done falls in the cycle after the last aux_rvalid.
- Boundary and ordering rules:
  - cpu_active=1 on a would-be issue cycle suppresses the issue only; already-issued reads still return and are tagged correctly.
  - A processor read's data is never flagged aux_rvalid.
  - aux_req while aux_busy=1 is ignored; no queueing.
  - A new aux_req is accepted in the same cycle aux_done is high, since the FSM is back in IDLE.
  - Address wrap: with base+idx crossing 2^ADDR_W-1, the next address is 0.
  - Reset mid-burst: the burst is abandoned, with no aux_done and no further aux_rvalid.
- Arithmetic: idx and remaining count are LEN_W bits and never overflow, because idx<=len.

Test Plan:
- Reset then idle, cpu_active=0, cpu_addr=5 → mem_addr=5, mem_wren=0; all aux_* outputs 0.
- aux_base=0x010, aux_len=4, RAM[n]=n*3, cpu idle → aux_rvalid on 4 consecutive cycles with data 0x30, 0x33, 0x36, 0x39, first valid 2 cycles after the first issue; aux_done 1 cycle after the last valid.
- Same burst with cpu_active=1 (sw addr 0x020, data 0xAB) in the cycle after the first issue → that cycle mem_wren=1, mem_addr=0x020; the burst stretches by 1 cycle; data order and values are unchanged; RAM[0x020]=0xAB.
- aux_base=0xFFE, aux_len=3 → addresses issued 0xFFE, 0xFFF, 0x000.
- aux_len=0 → aux_done pulses once, aux_busy stays 0, no aux issue cycles.
- reset asserted after 2 of 5 words → aux_busy=0 and aux_rvalid=0 immediately; no aux_done; the next aux_req is accepted normally.
